// File: rtl/lane_score_ctrl.sv
// rtl/lane_score_ctrl.sv - piano game progress controller: score, combo, miss map, level ladder, win/lose
//
// Ports:
//   clk       in   1              system clock
//   rst       in   1              synchronous active-low reset
//   ena       in   1              game running (0 = pause, all state frozen except edge registers)
//   hit       in   LANES          per-lane correct-press level
//   miss      in   LANES          per-lane wrong/missed-note level
//   target    in   LANES*TGT_W    key index of each lane's current note
//   score     out  SCORE_W        saturating score
//   slow      out  3              fall-speed divider (SLOW_MAX..1)
//   lane_en   out  LANES          lanes allowed to drop notes
//   level     out  4              current level
//   miss_map  out  KEYS           sticky per-key miss flags
//   win       out  1              game won
//   lose      out  1              game lost
module lane_score_ctrl #(
  parameter int LANES      = 3,
  parameter int KEYS       = 16,
  parameter int TGT_W      = 4,
  parameter int SCORE_W    = 11,
  parameter int HIT_PTS    = 3,
  parameter int COMBO_LEN  = 4,
  parameter int MISS_LIMIT = 8,
  parameter int LEVEL_STEP = 10,
  parameter int WIN_SCORE  = 60,
  parameter int SLOW_MAX   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [LANES-1:0]       hit,
  input  logic [LANES-1:0]       miss,
  input  logic [LANES*TGT_W-1:0] target,
  output logic [SCORE_W-1:0]     score,
  output logic [2:0]             slow,
  output logic [LANES-1:0]       lane_en,
  output logic [3:0]             level,
  output logic [KEYS-1:0]        miss_map,
  output logic                   win,
  output logic                   lose
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_WIN  = 2'd2,
    S_LOSE = 2'd3
  } state_t;

  // Wide enough to hold score plus LANES hits of (HIT_PTS+1) without wrapping.
  localparam int                 SUM_W     = SCORE_W + 12;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [LANES-1:0]     r_hit_prev;
  logic [LANES-1:0]     r_miss_prev;
  logic [SCORE_W-1:0]   r_score;
  logic [3:0]           r_combo;
  logic [3:0]           r_miss_cnt;
  logic [3:0]           r_level;
  logic [2:0]           r_slow;
  logic [LANES-1:0]     r_lane_en;
  logic [KEYS-1:0]      r_map;

  logic                 w_run;
  logic [LANES-1:0]     w_miss_edge;
  logic [LANES-1:0]     w_hit_acc;
  logic [LANES-1:0]     w_miss_acc;
  logic [3:0]           w_nhit;
  logic [3:0]           w_nmiss;
  logic [SUM_W-1:0]     w_pts_each;
  logic [SUM_W-1:0]     w_score_sum;
  logic [SCORE_W-1:0]   w_score_nxt;
  logic [4:0]           w_combo_sum;
  logic [3:0]           w_combo_nxt;
  logic [4:0]           w_miss_sum;
  logic [3:0]           w_miss_cnt_nxt;
  logic [KEYS-1:0]      w_map_nxt;
  logic [TGT_W-1:0]     w_tgt;
  logic                 w_exhausted;
  logic                 w_lvl_up;
  logic [3:0]           w_level_nxt;

  assign w_run       = (r_state == S_PLAY) && ena;
  assign w_miss_edge = miss & ~r_miss_prev;
  assign w_miss_acc  = w_miss_edge & r_lane_en & {LANES{w_run}};
  // A miss on the same lane in the same cycle discards that lane's hit.
  assign w_hit_acc   = hit & ~r_hit_prev & ~w_miss_edge & r_lane_en & {LANES{w_run}};

  always_comb begin
    w_nhit  = '0;
    w_nmiss = '0;
    for (int i = 0; i < LANES; i++) begin
      w_nhit  = w_nhit + 4'(w_hit_acc[i]);
      w_nmiss = w_nmiss + 4'(w_miss_acc[i]);
    end
  end

  // Bonus is decided by the combo count before this cycle, for all hits alike.
  assign w_pts_each  = SUM_W'(HIT_PTS) + ((32'(r_combo) >= COMBO_LEN) ? SUM_W'(1) : SUM_W'(0));
  assign w_score_sum = SUM_W'(r_score) + SUM_W'(w_nhit) * w_pts_each;
  assign w_score_nxt = (w_score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : w_score_sum[SCORE_W-1:0];

  assign w_combo_sum = {1'b0, r_combo} + {1'b0, w_nhit};
  assign w_combo_nxt = (|w_miss_acc) ? 4'd0 :
                       (w_combo_sum[4] ? 4'hF : w_combo_sum[3:0]);

  assign w_miss_sum     = {1'b0, r_miss_cnt} + {1'b0, w_nmiss};
  assign w_miss_cnt_nxt = w_miss_sum[4] ? 4'hF : w_miss_sum[3:0];

  // Clears are applied over all lanes before any set so a set always wins.
  always_comb begin
    w_map_nxt = r_map;
    w_tgt     = '0;
    for (int i = 0; i < LANES; i++) begin
      w_tgt = target[i*TGT_W +: TGT_W];
      if (w_hit_acc[i] && (32'(w_tgt) < KEYS)) begin
        w_map_nxt[w_tgt] = 1'b0;
      end
    end
    for (int i = 0; i < LANES; i++) begin
      w_tgt = target[i*TGT_W +: TGT_W];
      if (w_miss_acc[i] && (32'(w_tgt) < KEYS)) begin
        w_map_nxt[w_tgt] = 1'b1;
      end
    end
  end

  // Ladder runs off the registered score, so it trails a scoring edge by one cycle.
  assign w_exhausted = (&r_lane_en) && (r_slow == 3'd1);
  assign w_level_nxt = r_level + 4'd1;
  assign w_lvl_up    = w_run && !w_exhausted && (r_level != 4'hF) &&
                       (32'(r_score) >= (32'(r_level) + 32'd1) * LEVEL_STEP);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (ena) w_state_nxt = S_PLAY;
      end
      S_PLAY: begin
        if (ena) begin
          if (32'(r_miss_cnt) > MISS_LIMIT)       w_state_nxt = S_LOSE;
          else if (32'(r_score) >= WIN_SCORE)     w_state_nxt = S_WIN;
        end
      end
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_hit_prev  <= '0;
      r_miss_prev <= '0;
      r_score     <= '0;
      r_combo     <= '0;
      r_miss_cnt  <= '0;
      r_level     <= '0;
      r_slow      <= 3'(SLOW_MAX);
      r_lane_en   <= LANES'(1);
      r_map       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_hit_prev  <= hit;
      r_miss_prev <= miss;
      if (w_run) begin
        r_score    <= w_score_nxt;
        r_combo    <= w_combo_nxt;
        r_miss_cnt <= w_miss_cnt_nxt;
        r_map      <= w_map_nxt;
      end
      if (w_lvl_up) begin
        r_level <= w_level_nxt;
        if (w_level_nxt[0]) begin
          // Enabled lanes are always a contiguous run from lane 0.
          r_lane_en <= r_lane_en | (r_lane_en + LANES'(1));
        end else if (r_slow > 3'd1) begin
          r_slow <= r_slow - 3'd1;
        end
      end
    end
  end

  assign score    = r_score;
  assign slow     = r_slow;
  assign lane_en  = r_lane_en;
  assign level    = r_level;
  assign miss_map = r_map;
  assign win      = (r_state == S_WIN);
  assign lose     = (r_state == S_LOSE);

endmodule

// File: tb/tb_lane_score_ctrl.sv
// tb/tb_lane_score_ctrl.sv - self-checking bench for lane_score_ctrl
module tb_lane_score_ctrl;

  localparam int LANES      = 3;
  localparam int KEYS       = 16;
  localparam int TGT_W      = 4;
  localparam int SCORE_W    = 11;
  localparam int HIT_PTS    = 3;
  localparam int COMBO_LEN  = 4;
  localparam int MISS_LIMIT = 8;
  localparam int LEVEL_STEP = 10;
  localparam int WIN_SCORE  = 60;
  localparam int SLOW_MAX   = 3;
  localparam int SCORE_SAT  = (1 << SCORE_W) - 1;

  logic                   clk;
  logic                   rst;
  logic                   ena;
  logic [LANES-1:0]       hit;
  logic [LANES-1:0]       miss;
  logic [LANES*TGT_W-1:0] target;
  logic [SCORE_W-1:0]     score;
  logic [2:0]             slow;
  logic [LANES-1:0]       lane_en;
  logic [3:0]             level;
  logic [KEYS-1:0]        miss_map;
  logic                   win;
  logic                   lose;

  lane_score_ctrl #(
    .LANES(LANES), .KEYS(KEYS), .TGT_W(TGT_W), .SCORE_W(SCORE_W),
    .HIT_PTS(HIT_PTS), .COMBO_LEN(COMBO_LEN), .MISS_LIMIT(MISS_LIMIT),
    .LEVEL_STEP(LEVEL_STEP), .WIN_SCORE(WIN_SCORE), .SLOW_MAX(SLOW_MAX)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .hit(hit), .miss(miss), .target(target),
    .score(score), .slow(slow), .lane_en(lane_en), .level(level),
    .miss_map(miss_map), .win(win), .lose(lose)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: game state as plain integers and counts.
  int        m_state;   // 0 idle, 1 play, 2 win, 3 lose
  int        m_score, m_combo, m_mcnt, m_level, m_nlanes, m_slow;
  bit [15:0] m_map;
  bit [2:0]  m_hprev, m_mprev;

  typedef struct {
    logic       r;
    logic       e;
    logic [2:0] h;
    logic [2:0] m;
    int         score;
    int         level;
    int         lane_en;
    int         slow;
  } vec_t;

  vec_t tbl[$];

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit [2:0] he, me;
    int nh, nm, pts, tg, os, om;
    if (!rst) begin
      m_state = 0; m_score = 0; m_combo = 0; m_mcnt = 0; m_level = 0;
      m_nlanes = 1; m_slow = SLOW_MAX; m_map = '0; m_hprev = '0; m_mprev = '0;
      return;
    end
    me = miss & ~m_mprev;
    he = hit & ~m_hprev & ~me;
    m_hprev = hit;
    m_mprev = miss;
    if (m_state == 0) begin
      if (ena) m_state = 1;
      return;
    end
    if (m_state != 1 || !ena) return;
    os = m_score; om = m_mcnt; nh = 0; nm = 0;
    for (int i = 0; i < m_nlanes; i++) begin
      tg = int'((target >> (TGT_W * i)) & 12'hF);
      if (he[i]) begin nh++; if (tg < KEYS) m_map[tg] = 1'b0; end
    end
    for (int i = 0; i < m_nlanes; i++) begin
      tg = int'((target >> (TGT_W * i)) & 12'hF);
      if (me[i]) begin nm++; if (tg < KEYS) m_map[tg] = 1'b1; end
    end
    pts     = HIT_PTS + ((m_combo >= COMBO_LEN) ? 1 : 0);
    m_score = imin(os + nh * pts, SCORE_SAT);
    m_combo = (nm > 0) ? 0 : imin(m_combo + nh, 15);
    m_mcnt  = imin(om + nm, 15);
    if (os >= (m_level + 1) * LEVEL_STEP && !(m_nlanes == LANES && m_slow == 1)) begin
      m_level++;
      if (m_level % 2 == 1) begin
        if (m_nlanes < LANES) m_nlanes++;
      end else if (m_slow > 1) begin
        m_slow--;
      end
    end
    if (om > MISS_LIMIT)       m_state = 3;
    else if (os >= WIN_SCORE)  m_state = 2;
  endtask

  task automatic compare_model();
    chk("score", int'(score), m_score);
    chk("level", int'(level), m_level);
    chk("lane_en", int'(lane_en), (1 << m_nlanes) - 1);
    chk("slow", int'(slow), m_slow);
    chk("miss_map", int'(miss_map), int'(m_map));
    chk("win", int'(win), (m_state == 2) ? 1 : 0);
    chk("lose", int'(lose), (m_state == 3) ? 1 : 0);
  endtask

  task automatic step(input logic r, input logic e, input logic [2:0] h,
                      input logic [2:0] m, input logic [11:0] t);
    rst = r; ena = e; hit = h; miss = m; target = t;
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic start_game();
    step(1'b0, 1'b0, 3'b000, 3'b000, 12'h000);
    step(1'b1, 1'b1, 3'b000, 3'b000, 12'h000);
  endtask

  initial begin
    logic [2:0]  rh, rm;
    logic [11:0] rt;
    logic        rr, re;
    int          cyc;

    rst = 1'b0; ena = 1'b0; hit = '0; miss = '0; target = '0;

    // Directed table: scoring, level-up, combo bonus, combo reset, held level, disabled lane.
    tbl.push_back('{1'b0, 1'b0, 3'b000, 3'b000,  0, 0, 1, 3});
    tbl.push_back('{1'b1, 1'b1, 3'b000, 3'b000,  0, 0, 1, 3});
    tbl.push_back('{1'b1, 1'b1, 3'b001, 3'b000,  3, 0, 1, 3});
    tbl.push_back('{1'b1, 1'b1, 3'b000, 3'b000,  3, 0, 1, 3});
    tbl.push_back('{1'b1, 1'b1, 3'b001, 3'b000,  6, 0, 1, 3});
    tbl.push_back('{1'b1, 1'b1, 3'b000, 3'b000,  6, 0, 1, 3});
    tbl.push_back('{1'b1, 1'b1, 3'b001, 3'b000,  9, 0, 1, 3});
    tbl.push_back('{1'b1, 1'b1, 3'b000, 3'b000,  9, 0, 1, 3});
    tbl.push_back('{1'b1, 1'b1, 3'b001, 3'b000, 12, 0, 1, 3});
    tbl.push_back('{1'b1, 1'b1, 3'b000, 3'b000, 12, 1, 3, 3});
    tbl.push_back('{1'b1, 1'b1, 3'b001, 3'b000, 16, 1, 3, 3});
    tbl.push_back('{1'b1, 1'b1, 3'b000, 3'b000, 16, 1, 3, 3});
    tbl.push_back('{1'b1, 1'b1, 3'b000, 3'b001, 16, 1, 3, 3});
    tbl.push_back('{1'b1, 1'b1, 3'b000, 3'b000, 16, 1, 3, 3});
    tbl.push_back('{1'b1, 1'b1, 3'b001, 3'b000, 19, 1, 3, 3});
    tbl.push_back('{1'b1, 1'b1, 3'b001, 3'b000, 19, 1, 3, 3});
    tbl.push_back('{1'b1, 1'b1, 3'b001, 3'b000, 19, 1, 3, 3});
    tbl.push_back('{1'b1, 1'b1, 3'b100, 3'b000, 19, 1, 3, 3});
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].h, tbl[i].m, 12'h000);
      chk($sformatf("tbl%0d_score", i), int'(score), tbl[i].score);
      chk($sformatf("tbl%0d_level", i), int'(level), tbl[i].level);
      chk($sformatf("tbl%0d_lane_en", i), int'(lane_en), tbl[i].lane_en);
      chk($sformatf("tbl%0d_slow", i), int'(slow), tbl[i].slow);
    end

    // Same-lane hit+miss on lane 1 -> miss wins, combo cleared; later hit clears the key.
    start_game();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 3'b001, 3'b000, 12'h000);
      step(1'b1, 1'b1, 3'b000, 3'b000, 12'h000);
    end
    chk("mm_lane_en", int'(lane_en), 3);
    step(1'b1, 1'b1, 3'b010, 3'b010, 12'h050);
    chk("mm_score_same", int'(score), 12);
    chk("mm_bit5_set", int'(miss_map[5]), 1);
    step(1'b1, 1'b1, 3'b000, 3'b000, 12'h050);
    step(1'b1, 1'b1, 3'b010, 3'b000, 12'h050);
    chk("mm_no_bonus", int'(score), 15);
    chk("mm_bit5_clr", int'(miss_map[5]), 0);

    // Nine accepted misses -> lose one cycle later; score frozen; reset with a live hit.
    start_game();
    for (int k = 0; k < 9; k++) begin
      step(1'b1, 1'b1, 3'b000, 3'b001, 12'h000);
      if (k == 8) chk("lose_at_9th", int'(lose), 0);
      step(1'b1, 1'b1, 3'b000, 3'b000, 12'h000);
    end
    chk("lose_after_9th", int'(lose), 1);
    step(1'b1, 1'b1, 3'b001, 3'b000, 12'h000);
    step(1'b1, 1'b1, 3'b000, 3'b000, 12'h000);
    chk("lose_frozen", int'(score), 0);
    step(1'b0, 1'b1, 3'b001, 3'b000, 12'h000);
    chk("rst_lose", int'(lose), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_map", int'(miss_map), 0);
    step(1'b1, 1'b1, 3'b001, 3'b000, 12'h000);
    chk("idle_drop", int'(score), 0);
    step(1'b1, 1'b1, 3'b000, 3'b000, 12'h000);
    step(1'b1, 1'b1, 3'b001, 3'b000, 12'h000);
    chk("replay_hit", int'(score), 3);

    // Pause: pulses ignored; resuming with hit held gives no credit.
    start_game();
    step(1'b1, 1'b1, 3'b001, 3'b000, 12'h000);
    step(1'b1, 1'b0, 3'b000, 3'b000, 12'h000);
    step(1'b1, 1'b0, 3'b001, 3'b000, 12'h000);
    step(1'b1, 1'b0, 3'b000, 3'b000, 12'h000);
    step(1'b1, 1'b0, 3'b001, 3'b000, 12'h000);
    chk("pause_frozen", int'(score), 3);
    step(1'b1, 1'b1, 3'b001, 3'b000, 12'h000);
    chk("resume_no_credit", int'(score), 3);
    step(1'b1, 1'b1, 3'b000, 3'b000, 12'h000);
    step(1'b1, 1'b1, 3'b001, 3'b000, 12'h000);
    chk("resume_hit", int'(score), 6);

    // Climb to a win with all lanes pulsing.
    start_game();
    cyc = 0;
    while (!win && cyc < 300) begin
      step(1'b1, 1'b1, 3'b111, 3'b000, 12'h000);
      step(1'b1, 1'b1, 3'b000, 3'b000, 12'h000);
      cyc++;
    end
    step(1'b1, 1'b1, 3'b000, 3'b000, 12'h000);
    chk("win_flag", int'(win), 1);
    chk("win_lose", int'(lose), 0);
    chk("win_level", int'(level), 4);
    chk("win_lane_en", int'(lane_en), 7);
    chk("win_slow", int'(slow), 1);
    chk("win_score_ge", (int'(score) >= WIN_SCORE) ? 1 : 0, 1);

    // Random stimulus against the reference model.
    start_game();
    for (int n = 0; n < 4000; n++) begin
      rr = !((m_state >= 2 && $urandom_range(0, 19) == 0) || $urandom_range(0, 599) == 0);
      re = ($urandom_range(0, 9) != 0);
      for (int b = 0; b < LANES; b++) begin
        rh[b] = ($urandom_range(0, 2) == 0);
        rm[b] = ($urandom_range(0, 11) == 0);
      end
      rt = 12'($urandom);
      step(rr, re, rh, rm, rt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
